booth_product_accumulator: RTL and testbench
============================================

# booth_product_accumulator

Downstream stage for the Booth multiplier: accepts a stream of signed two's-complement products over a valid/ready handshake. It sign-extends each product and sums a fixed group of `N_TERMS` products into a wider accumulator. It then presents the group result with a sticky overflow flag, holding it until the consumer takes it. This forms the accumulate half of the lab's multiply-accumulate datapath.

## Interface
- `PW`, 6: product width; two's-complement input from the multiplier.
- `AW`, 10: accumulator/result width, signed; must be ≥ `PW`.
- `N_TERMS`, 4: products per group; must be ≥ 1.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `p_valid` input 1: product on `p_data` is valid.
- `p_ready` output 1: block accepts a product this cycle.
- `p_data` input PW: signed product.
- `clear` input 1: synchronous abort of the current group.
- `acc_valid` output 1: group result valid.
- `acc_ready` input 1: consumer takes the result.
- `acc_data` output AW: signed group sum.
- `acc_count` output $clog2(N_TERMS+1): products accepted in the current group.
- `acc_ovf` output 1: sticky overflow for the current group.

## Operation
- FSM has two states, encoded `ACC`=0 and `DONE`=1.
- **Accept rule:** `p_ready = (state==ACC) && !clear`. A product is accepted when `p_valid && p_ready`.
- **ACC, on accept:**
  - `acc <= acc + sext(p_data)`, computed at AW+1 bits.
  - Overflow occurs when the two top bits of the sum differ; it sets `acc_ovf`, which stays set until the group ends.
  - `acc_count` increments.
  - On the accept that brings the count to `N_TERMS`, go to `DONE`.
- **ACC, with `clear`:** `acc`, `acc_count` and `acc_ovf` go to 0. Any product presented that cycle is not accepted, because `p_ready` is low.
- **DONE:**
  - `acc_valid=1`, `p_ready=0`.
  - `acc_data`, `acc_count` and `acc_ovf` are frozen.
  - `clear` is ignored.
- **DONE, on `acc_ready`:** go to `ACC` with `acc`, `acc_count` and `acc_ovf` all 0.
- **Wrap vs saturate:** overflow handling follows Configuration. `acc_ovf` behaviour is identical in both modes.

## Timing
- **Reset values** (in the cycle after `rst` is sampled high):
  - state `ACC`; `acc_data=0`, `acc_count=0`, `acc_ovf=0`, `acc_valid=0`.
  - `p_ready=0` while `rst` is high; `p_ready=1` the cycle after release.
- **`rst` mid-group or in DONE:** discards everything; no result is emitted.
- **Throughput:** one product per cycle in `ACC`.
- **Latency:** `acc_valid` rises the cycle after the `N_TERMS`-th accept.
- **Output timing:** `acc_valid`, `acc_data` and `acc_ovf` are registered outputs.
- **Result release:** if `acc_valid && acc_ready` at edge k, `p_ready` is high in cycle k+1. That gives a minimum of 1 idle input cycle per group.
- **`p_ready` path:** combinational from state and `clear` only; there is no path from `p_valid`.
- **`N_TERMS=1`:** every accept goes straight to `DONE`.

## Configuration
- Macro: `BOOTH_ACC_SATURATE_EN`.
- **Defined:** on overflow, `acc` clamps to +2^(AW-1)-1 or -2^(AW-1), according to the sign of the true sum. Subsequent adds start from the clamped value.
- **Undefined:** `acc` wraps modulo 2^AW.
- `acc_ovf` is set identically in both modes.

## Structure
- **Package `booth_pkg`:**
  - default `PW`/`AW`/`N_TERMS` constants;
  - state encoding localparams `ACC`/`DONE`;
  - sign-extend helper function.
- **Sub-module `booth_sat_add`:**
  - combinational signed add of width AW;
  - outputs `sum` and `ovf`;
  - contains the `BOOTH_ACC_SATURATE_EN` wrap/clamp logic.
- **FSM, counter and handshake:** these stay in the top module.

## Test plan
1. **Mixed-sign group:**
   - Stimulus: defaults; back-to-back products 2, -6, 3, 1 (`000010`, `111010`, `000011`, `000001`); `acc_ready=1`.
   - Response: `acc_valid` is high 1 cycle after the 4th accept, with `acc_data=0`, `acc_count=4`, `acc_ovf=0`.
2. **Negative extreme:**
   - Stimulus: four products of -32 (`100000`).
   - Response: `acc_data=10'b1110000000` (-128), `acc_ovf=0`.
3. **Overflow:**
   - Stimulus: `AW=7`, products 31, 31, 31, 31.
   - Response, macro undefined: `acc_data=7'b1111100` (-4), `acc_ovf=1`.
   - Response, macro defined: `acc_data=63`, `acc_ovf=1`.
   - `acc_ovf` must be set from the 3rd accept onward in both modes.
4. **Backpressure:**
   - Stimulus: after a group completes, hold `acc_ready=0` for 3 cycles with `p_valid=1`.
   - Response: `acc_data` is stable and `p_ready=0` throughout. After `acc_ready`, the next group sums from 0.
5. **Clear mid-group:**
   - Stimulus: accept 5 and 7, then assert `clear` with `p_valid=1` and `p_data=9`.
   - Response: 9 is not accepted; `acc_data=0` and `acc_count=0` next cycle. Products 1, 1, 1, 1 then yield 4.
6. **Reset mid-operation:**
   - Stimulus: assert `rst` for 1 cycle, once after 2 accepts and once in `DONE`.
   - Response: all outputs are 0 and `acc_valid` does not pulse. A fresh group then completes correctly.

Source files
------------

// File: rtl/booth_pkg.sv
// Purpose: shared defaults, FSM state encoding and the sign-extension helper for the accumulator.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package booth_pkg;

    localparam int PW_DEF      = 6;
    localparam int AW_DEF      = 10;
    localparam int N_TERMS_DEF = 4;

    // ACC collects products; DONE holds the group result for the consumer
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Sign-extend the low `width` bits of val to 32 bits; callers truncate to their own width
    function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned width);
        logic signed [31:0] shifted;
        shifted = $signed(val << (32 - width));
        return shifted >>> (32 - width);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Purpose: signed AW-bit add with overflow flag; clamps when BOOTH_ACC_SATURATE_EN is defined, wraps otherwise.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW:0] wide;

    // Add at AW+1 bits so the true sign survives; overflow when the top two bits disagree
    always_comb begin
        wide = {a[AW-1], a} + {b[AW-1], b};
        ovf  = wide[AW] ^ wide[AW-1];
`ifdef BOOTH_ACC_SATURATE_EN
        if (ovf) begin
            sum = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            sum = wide[AW-1:0];
        end
`else
        sum = wide[AW-1:0];
`endif
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Purpose: sums groups of N_TERMS signed products into an AW-bit result with sticky overflow (BOOTH_ACC_SATURATE_EN selects clamp vs wrap).
// Latency: acc_valid rises the cycle after the N_TERMS-th accepted product.
// Backpressure: p_ready drops while a result waits for acc_ready, and while clear or rst is high.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter  int PW      = PW_DEF,
    parameter  int AW      = AW_DEF,
    parameter  int N_TERMS = N_TERMS_DEF,
    localparam int CW      = $clog2(N_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [PW-1:0] p_data,
    input  logic          clear,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc_data,
    output logic [CW-1:0] acc_count,
    output logic          acc_ovf
);

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;
    logic [AW-1:0] addend;
    logic [AW-1:0] add_sum;
    logic          add_ovf;
    logic          accept;
    logic          last_term;

    // Ready depends only on state, clear and reset so no valid-to-ready loop can form
    assign p_ready   = (state == ACC) && !clear && !rst;
    assign accept    = p_valid && p_ready;
    assign addend    = AW'(sext(32'(p_data), PW));
    assign last_term = (count == CW'(N_TERMS - 1));

    booth_sat_add #(
        .AW (AW)
    ) u_add (
        .a   (acc),
        .b   (addend),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Group FSM: accumulate accepted products, then hold the result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            count     <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (clear) begin
                        acc     <= '0;
                        count   <= '0;
                        acc_ovf <= 1'b0;
                    end else if (accept) begin
                        acc     <= add_sum;
                        count   <= count + 1'b1;
                        acc_ovf <= acc_ovf | add_ovf;
                        if (last_term) begin
                            state     <= DONE;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        state     <= ACC;
                        acc_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        acc_ovf   <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign acc_data  = acc;
    assign acc_count = count;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Purpose: self-checking bench for booth_product_accumulator (default AW=10 instance and AW=7 overflow instance).
// Latency: not applicable.
// Backpressure: exercised by holding acc_ready low and by clear.
module tb_booth_product_accumulator;

    localparam int PW   = 6;
    localparam int AW_A = 10;
    localparam int AW_B = 7;
    localparam int NT   = 4;
    localparam int CW   = 3;

`ifdef BOOTH_ACC_SATURATE_EN
    localparam int OVF_DATA3 = 63;
    localparam int OVF_DATA4 = 63;
`else
    localparam int OVF_DATA3 = -35;
    localparam int OVF_DATA4 = -4;
`endif

    typedef struct {
        int p0;
        int p1;
        int p2;
        int p3;
        int exp_data;
        bit exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic            a_p_valid, a_p_ready, a_clear, a_acc_valid, a_acc_ready, a_acc_ovf;
    logic [PW-1:0]   a_p_data;
    logic [AW_A-1:0] a_acc_data;
    logic [CW-1:0]   a_acc_count;

    logic            b_p_valid, b_p_ready, b_clear, b_acc_valid, b_acc_ready, b_acc_ovf;
    logic [PW-1:0]   b_p_data;
    logic [AW_B-1:0] b_acc_data;
    logic [CW-1:0]   b_acc_count;

    int n_cmp = 0;
    int n_bad = 0;
    int prods[4];
    vec_t tbl[5];

    always #5 clk = ~clk;

    booth_product_accumulator #(.PW(PW), .AW(AW_A), .N_TERMS(NT)) dut_a (
        .clk(clk), .rst(rst), .p_valid(a_p_valid), .p_ready(a_p_ready), .p_data(a_p_data),
        .clear(a_clear), .acc_valid(a_acc_valid), .acc_ready(a_acc_ready), .acc_data(a_acc_data),
        .acc_count(a_acc_count), .acc_ovf(a_acc_ovf)
    );

    booth_product_accumulator #(.PW(PW), .AW(AW_B), .N_TERMS(NT)) dut_b (
        .clk(clk), .rst(rst), .p_valid(b_p_valid), .p_ready(b_p_ready), .p_data(b_p_data),
        .clear(b_clear), .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_data(b_acc_data),
        .acc_count(b_acc_count), .acc_ovf(b_acc_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Group sum from plain integer arithmetic: wrap or clamp whenever the running sum leaves the signed range
    function automatic void model(input int ps[4], input int aw, output int data, output bit ovf);
        int hi;
        int lo;
        int s;
        hi  = (1 << (aw - 1)) - 1;
        lo  = -(1 << (aw - 1));
        s   = 0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = s + ps[i];
            if (s > hi || s < lo) begin
                ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? s - (1 << aw) : s + (1 << aw);
`endif
            end
        end
        data = s;
    endfunction

    // Present prods[0..n-1] on instance A, one accept per product
    task automatic feed_a(input string name, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            a_p_valid = 1'b1;
            a_p_data  = PW'(prods[i]);
            #1;
            guard = 0;
            while (!a_p_ready && guard < 20) begin
                tick();
                guard++;
            end
            chk({name, " p_ready before accept"}, a_p_ready, 1);
            chk({name, " acc_valid early"}, a_acc_valid, 0);
            tick();
        end
        a_p_valid = 1'b0;
    endtask

    task automatic check_a(input string name, input int exp_data, input bit exp_ovf);
        chk({name, " acc_valid"}, a_acc_valid, 1);
        chk({name, " acc_data"}, $signed(a_acc_data), exp_data);
        chk({name, " acc_count"}, a_acc_count, NT);
        chk({name, " acc_ovf"}, a_acc_ovf, exp_ovf);
    endtask

    task automatic release_a(input string name);
        a_acc_ready = 1'b1;
        tick();
        a_acc_ready = 1'b0;
        chk({name, " valid after release"}, a_acc_valid, 0);
        chk({name, " data after release"}, $signed(a_acc_data), 0);
        chk({name, " count after release"}, a_acc_count, 0);
        chk({name, " p_ready after release"}, a_p_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ps[4];
        int k;
        int guard;
        int md;
        bit mo;
        int stall;

        rst = 1'b1;
        a_p_valid = 1'b0; a_p_data = '0; a_clear = 1'b0; a_acc_ready = 1'b0;
        b_p_valid = 1'b0; b_p_data = '0; b_clear = 1'b0; b_acc_ready = 1'b0;
        tick();
        tick();
        chk("reset p_ready", a_p_ready, 0);
        chk("reset acc_valid", a_acc_valid, 0);
        chk("reset acc_data", $signed(a_acc_data), 0);
        chk("reset acc_count", a_acc_count, 0);
        chk("reset acc_ovf", a_acc_ovf, 0);
        chk("reset b acc_valid", b_acc_valid, 0);
        rst = 1'b0;
        #1;
        chk("p_ready after reset release", a_p_ready, 1);
        tick();

        // Table-driven groups on the default instance
        tbl[0] = '{2, -6, 3, 1, 0, 1'b0};
        tbl[1] = '{-32, -32, -32, -32, -128, 1'b0};
        tbl[2] = '{31, 31, 31, 31, 124, 1'b0};
        tbl[3] = '{-1, -1, -1, -1, -4, 1'b0};
        tbl[4] = '{17, -20, 0, 5, 2, 1'b0};
        for (int t = 0; t < 5; t++) begin
            prods[0] = tbl[t].p0;
            prods[1] = tbl[t].p1;
            prods[2] = tbl[t].p2;
            prods[3] = tbl[t].p3;
            feed_a($sformatf("vec%0d", t), 4);
            check_a($sformatf("vec%0d", t), tbl[t].exp_data, tbl[t].exp_ovf);
            release_a($sformatf("vec%0d", t));
        end

        // Backpressure: result held, input blocked while acc_ready is low
        prods = '{9, -3, 4, 10};
        feed_a("bp", 4);
        a_p_valid = 1'b1;
        a_p_data  = PW'(5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp p_ready held low", a_p_ready, 0);
            chk("bp acc_valid held", a_acc_valid, 1);
            chk("bp acc_data stable", $signed(a_acc_data), 20);
            tick();
        end
        a_p_valid = 1'b0;
        check_a("bp", 20, 1'b0);
        release_a("bp");
        prods = '{1, 1, 1, 1};
        feed_a("bp next", 4);
        check_a("bp next", 4, 1'b0);
        release_a("bp next");

        // Clear mid-group drops the partial sum and refuses the product offered with it
        prods = '{5, 7, 0, 0};
        feed_a("clr", 2);
        chk("clr partial data", $signed(a_acc_data), 12);
        chk("clr partial count", a_acc_count, 2);
        a_clear   = 1'b1;
        a_p_valid = 1'b1;
        a_p_data  = PW'(9);
        #1;
        chk("clr p_ready low", a_p_ready, 0);
        tick();
        a_clear   = 1'b0;
        a_p_valid = 1'b0;
        chk("clr acc_data", $signed(a_acc_data), 0);
        chk("clr acc_count", a_acc_count, 0);
        prods = '{1, 1, 1, 1};
        feed_a("clr after", 4);
        check_a("clr after", 4, 1'b0);

        // Clear is ignored while a result is waiting
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check_a("clr in done", 4, 1'b0);
        release_a("clr in done");

        // Reset mid-group
        prods = '{5, 7, 0, 0};
        feed_a("rst mid", 2);
        rst = 1'b1;
        #1;
        chk("rst mid p_ready", a_p_ready, 0);
        tick();
        rst = 1'b0;
        chk("rst mid acc_valid", a_acc_valid, 0);
        chk("rst mid acc_data", $signed(a_acc_data), 0);
        chk("rst mid acc_count", a_acc_count, 0);
        chk("rst mid acc_ovf", a_acc_ovf, 0);

        // Reset while a result waits
        prods = '{2, 2, 2, 2};
        feed_a("rst done", 4);
        check_a("rst done pre", 8, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst done acc_valid", a_acc_valid, 0);
        chk("rst done acc_data", $signed(a_acc_data), 0);
        chk("rst done acc_count", a_acc_count, 0);
        tick();
        chk("rst done no pulse", a_acc_valid, 0);
        prods = '{3, -1, 3, -1};
        feed_a("rst fresh", 4);
        check_a("rst fresh", 4, 1'b0);
        release_a("rst fresh");

        // Overflow on the narrow instance: 31 x 4 with AW=7
        for (int i = 0; i < 4; i++) begin
            b_p_valid = 1'b1;
            b_p_data  = PW'(31);
            #1;
            chk("ovf p_ready", b_p_ready, 1);
            tick();
            chk($sformatf("ovf flag after accept %0d", i + 1), b_acc_ovf, (i >= 2) ? 1 : 0);
            if (i == 2) chk("ovf data after 3rd", $signed(b_acc_data), OVF_DATA3);
        end
        b_p_valid = 1'b0;
        chk("ovf acc_valid", b_acc_valid, 1);
        chk("ovf acc_data", $signed(b_acc_data), OVF_DATA4);
        chk("ovf acc_count", b_acc_count, NT);
        b_acc_ready = 1'b1;
        tick();
        b_acc_ready = 1'b0;
        chk("ovf release valid", b_acc_valid, 0);
        chk("ovf release ovf", b_acc_ovf, 0);
        chk("ovf release data", $signed(b_acc_data), 0);

        // Randomized groups with gaps, occasional clear and random consumer stalls
        for (int g = 0; g < 40; g++) begin
            k = 0;
            guard = 0;
            while (k < 4 && guard < 200) begin
                b_p_valid = ($urandom_range(0, 3) != 0);
                b_p_data  = PW'($urandom);
                b_clear   = (k > 0) && ($urandom_range(0, 15) == 0);
                #1;
                if (b_clear) begin
                    chk("rnd p_ready under clear", b_p_ready, 0);
                    k = 0;
                end else if (b_p_valid && b_p_ready) begin
                    ps[k] = int'($signed(b_p_data));
                    k++;
                end
                tick();
                guard++;
            end
            b_p_valid = 1'b0;
            b_clear   = 1'b0;
            model(ps, AW_B, md, mo);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                chk($sformatf("rnd%0d stall valid", g), b_acc_valid, 1);
                chk($sformatf("rnd%0d stall data", g), $signed(b_acc_data), md);
                tick();
            end
            chk($sformatf("rnd%0d acc_valid", g), b_acc_valid, 1);
            chk($sformatf("rnd%0d acc_data", g), $signed(b_acc_data), md);
            chk($sformatf("rnd%0d acc_ovf", g), b_acc_ovf, mo);
            chk($sformatf("rnd%0d acc_count", g), b_acc_count, NT);
            b_acc_ready = 1'b1;
            tick();
            b_acc_ready = 1'b0;
            chk($sformatf("rnd%0d released", g), b_acc_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
